// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use interlock, EX-stage redirect, memory-wait
// stall with timeout, and a saturating stall counter. Synchronous active-low reset.
module hazard_ctrl #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1_addr,
  input  logic [4:0]       id_rs2_addr,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd_addr,
  input  logic             ex_is_load,
  input  logic             ex_wb_en,
  input  logic             ex_redirect,
  input  logic [31:0]      ex_redirect_pc,
  input  logic             mem_req,
  input  logic             mem_ack,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             id_ex_stall,
  output logic             ex_mem_stall,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             pc_sel,
  output logic [31:0]      pc_redirect,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [1:0]       state_o
);

  localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_REDIR    = 2'd2;
  localparam logic [1:0] ST_ERR      = 2'd3;

  logic [1:0]        state, state_nxt;
  logic              pend, pend_nxt;
  logic [31:0]       pend_pc, pend_pc_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic              mem_err_nxt;

  logic              load_use;
  logic              mem_busy;

  // Raw control requests before flush-over-stall resolution.
  logic              pc_stall_raw;
  logic              if_id_stall_raw;
  logic              id_ex_stall_raw;
  logic              ex_mem_stall_raw;
  logic              if_id_flush_raw;
  logic              id_ex_flush_raw;
  logic              pc_sel_raw;
  logic [31:0]       pc_tgt_raw;

  assign load_use = ex_is_load && ex_wb_en && (ex_rd_addr != 5'd0) &&
                    ((id_uses_rs1 && (id_rs1_addr == ex_rd_addr)) ||
                     (id_uses_rs2 && (id_rs2_addr == ex_rd_addr)));

  assign mem_busy = mem_req && !mem_ack;

  // ---------------------------------------------------------------------------
  // Combinational stage control, valid in the same cycle as the inputs.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output gets a default before the case so no latch is inferred.
    pc_stall_raw     = 1'b0;
    if_id_stall_raw  = 1'b0;
    id_ex_stall_raw  = 1'b0;
    ex_mem_stall_raw = 1'b0;
    if_id_flush_raw  = 1'b0;
    id_ex_flush_raw  = 1'b0;
    pc_sel_raw       = 1'b0;
    pc_tgt_raw       = 32'd0;

    if (!rst) begin
      // Fill the front of the pipe with bubbles while reset is held.
      if_id_flush_raw = 1'b1;
      id_ex_flush_raw = 1'b1;
    end else begin
      case (state)
        ST_RUN: begin
          if (mem_busy) begin
            pc_stall_raw     = 1'b1;
            if_id_stall_raw  = 1'b1;
            id_ex_stall_raw  = 1'b1;
            ex_mem_stall_raw = 1'b1;
          end else if (ex_redirect) begin
            pc_sel_raw      = 1'b1;
            pc_tgt_raw      = ex_redirect_pc;
            if_id_flush_raw = 1'b1;
            id_ex_flush_raw = 1'b1;
          end else if (load_use) begin
            pc_stall_raw    = 1'b1;
            if_id_stall_raw = 1'b1;
            id_ex_flush_raw = 1'b1;
          end
        end
        ST_MEM_WAIT: begin
          // On the ack cycle everything releases; any redirect is replayed from REDIR.
          if (!mem_ack) begin
            pc_stall_raw     = 1'b1;
            if_id_stall_raw  = 1'b1;
            id_ex_stall_raw  = 1'b1;
            ex_mem_stall_raw = 1'b1;
          end
        end
        ST_REDIR: begin
          pc_sel_raw      = 1'b1;
          pc_tgt_raw      = pend_pc;
          if_id_flush_raw = 1'b1;
          id_ex_flush_raw = 1'b1;
        end
        default: begin
          pc_stall_raw     = 1'b1;
          if_id_stall_raw  = 1'b1;
          id_ex_stall_raw  = 1'b1;
          ex_mem_stall_raw = 1'b1;
        end
      endcase
    end
  end

  // A bubble overrides a hold on the same stage register.
  assign pc_stall     = pc_stall_raw;
  assign if_id_stall  = if_id_stall_raw & ~if_id_flush_raw;
  assign id_ex_stall  = id_ex_stall_raw & ~id_ex_flush_raw;
  assign ex_mem_stall = ex_mem_stall_raw;
  assign if_id_flush  = if_id_flush_raw;
  assign id_ex_flush  = id_ex_flush_raw;
  assign pc_sel       = pc_sel_raw;
  assign pc_redirect  = pc_sel_raw ? pc_tgt_raw : 32'd0;

  assign state_o = state;

  // ---------------------------------------------------------------------------
  // Next-state logic.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt    = state;
    pend_nxt     = pend;
    pend_pc_nxt  = pend_pc;
    wait_cnt_nxt = wait_cnt;
    mem_err_nxt  = mem_err;

    case (state)
      ST_RUN: begin
        if (mem_busy) begin
          state_nxt    = ST_MEM_WAIT;
          wait_cnt_nxt = WAIT_W'(1);
          if (ex_redirect) begin
            pend_nxt    = 1'b1;
            pend_pc_nxt = ex_redirect_pc;
          end
        end
      end
      ST_MEM_WAIT: begin
        // The first redirect seen while waiting is the one that gets replayed.
        if (ex_redirect && !pend) begin
          pend_nxt    = 1'b1;
          pend_pc_nxt = ex_redirect_pc;
        end
        if (mem_ack) begin
          state_nxt    = (pend || ex_redirect) ? ST_REDIR : ST_RUN;
          wait_cnt_nxt = '0;
        end else if (wait_cnt == WAIT_LIMIT) begin
          state_nxt   = ST_ERR;
          mem_err_nxt = 1'b1;
        end else begin
          wait_cnt_nxt = wait_cnt + WAIT_W'(1);
        end
      end
      ST_REDIR: begin
        state_nxt = ST_RUN;
        pend_nxt  = 1'b0;
      end
      default: begin
        state_nxt = ST_ERR;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst) begin
      state     <= ST_RUN;
      pend      <= 1'b0;
      pend_pc   <= 32'd0;
      wait_cnt  <= '0;
      mem_err   <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state    <= state_nxt;
      pend     <= pend_nxt;
      pend_pc  <= pend_pc_nxt;
      wait_cnt <= wait_cnt_nxt;
      mem_err  <= mem_err_nxt;
      if (pc_stall && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios followed by random
// stimulus, all compared against a cycle-level behavioural model.
module tb_hazard_ctrl;

  localparam int CNT_W   = 4;
  localparam int TIMEOUT = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [4:0]       id_rs1_addr, id_rs2_addr, ex_rd_addr;
  logic             id_uses_rs1, id_uses_rs2;
  logic             ex_is_load, ex_wb_en, ex_redirect;
  logic [31:0]      ex_redirect_pc;
  logic             mem_req, mem_ack;
  logic             pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
  logic             if_id_flush, id_ex_flush, pc_sel;
  logic [31:0]      pc_redirect;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [1:0]       state_o;

  always #5 clk = ~clk;

  hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd_addr(ex_rd_addr), .ex_is_load(ex_is_load), .ex_wb_en(ex_wb_en),
    .ex_redirect(ex_redirect), .ex_redirect_pc(ex_redirect_pc),
    .mem_req(mem_req), .mem_ack(mem_ack),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .id_ex_stall(id_ex_stall),
    .ex_mem_stall(ex_mem_stall), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .pc_sel(pc_sel), .pc_redirect(pc_redirect), .mem_err(mem_err),
    .stall_cnt(stall_cnt), .state_o(state_o)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", tag, cyc, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum int {M_RUN = 0, M_WAIT = 1, M_REDIR = 2, M_ERR = 3} mode_t;

  typedef struct {
    bit          st_pc, st_ifid, st_idex, st_exmem;
    bit          fl_ifid, fl_idex, sel;
    logic [31:0] tgt;
  } exp_t;

  mode_t       m_mode;
  bit          m_pend;
  logic [31:0] m_pend_pc;
  int          m_wait;
  int          m_cnt;
  bit          m_err;

  function automatic bit hazard();
    bit hit1, hit2;
    hit1 = id_uses_rs1 && (id_rs1_addr == ex_rd_addr);
    hit2 = id_uses_rs2 && (id_rs2_addr == ex_rd_addr);
    return ex_is_load && ex_wb_en && (ex_rd_addr != 0) && (hit1 || hit2);
  endfunction

  function automatic exp_t expect_now();
    exp_t e;
    e = '{default: 0};
    if (!rst) begin
      e.fl_ifid = 1; e.fl_idex = 1;
    end else if (m_mode == M_ERR || (m_mode == M_WAIT && !mem_ack) ||
                 (m_mode == M_RUN && mem_req && !mem_ack)) begin
      e.st_pc = 1; e.st_ifid = 1; e.st_idex = 1; e.st_exmem = 1;
    end else if (m_mode == M_REDIR) begin
      e.sel = 1; e.tgt = m_pend_pc; e.fl_ifid = 1; e.fl_idex = 1;
    end else if (m_mode == M_RUN && ex_redirect) begin
      e.sel = 1; e.tgt = ex_redirect_pc; e.fl_ifid = 1; e.fl_idex = 1;
    end else if (m_mode == M_RUN && hazard()) begin
      e.st_pc = 1; e.st_ifid = 1; e.fl_idex = 1;
    end
    return e;
  endfunction

  task automatic model_reset();
    m_mode = M_RUN; m_pend = 0; m_pend_pc = 0; m_wait = 0; m_cnt = 0; m_err = 0;
  endtask

  task automatic advance(input exp_t e);
    if (!rst) begin
      model_reset();
      return;
    end
    if (e.st_pc && m_cnt < CNT_MAX) m_cnt++;
    case (m_mode)
      M_RUN: if (mem_req && !mem_ack) begin
        m_mode = M_WAIT; m_wait = 1;
        if (ex_redirect) begin m_pend = 1; m_pend_pc = ex_redirect_pc; end
      end
      M_WAIT: begin
        if (ex_redirect && !m_pend) begin m_pend = 1; m_pend_pc = ex_redirect_pc; end
        if (mem_ack) begin
          m_mode = m_pend ? M_REDIR : M_RUN; m_wait = 0;
        end else if (m_wait == TIMEOUT) begin
          m_mode = M_ERR; m_err = 1;
        end else begin
          m_wait++;
        end
      end
      M_REDIR: begin m_mode = M_RUN; m_pend = 0; end
      default: ;
    endcase
  endtask

  // One clock: inputs are already applied just after the previous edge.
  task automatic step();
    exp_t e;
    #3;
    e = expect_now();
    check("stalls", {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall},
          {e.st_pc, e.st_ifid, e.st_idex, e.st_exmem});
    check("flushes", {if_id_flush, id_ex_flush}, {e.fl_ifid, e.fl_idex});
    check("pc_sel", pc_sel, e.sel);
    check("pc_redirect", pc_redirect, e.tgt);
    check("state_o", state_o, 32'(m_mode));
    check("stall_cnt", stall_cnt, m_cnt);
    check("mem_err", mem_err, m_err);
    @(posedge clk);
    advance(e);
    cyc++;
    #1;
  endtask

  task automatic idle_inputs();
    rst = 1; id_rs1_addr = 0; id_rs2_addr = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    ex_rd_addr = 0; ex_is_load = 0; ex_wb_en = 0; ex_redirect = 0;
    ex_redirect_pc = 0; mem_req = 0; mem_ack = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 0;
    step();
    rst = 1;
  endtask

  initial begin
    idle_inputs();
    rst = 0;
    model_reset();
    @(posedge clk);
    #1;

    // Reset with busy inputs: bubbles only, registers cleared.
    ex_redirect = 1; ex_redirect_pc = 32'h1234; mem_req = 1;
    step();
    idle_inputs();
    check("reset_state", state_o, 0);
    check("reset_cnt", stall_cnt, 0);

    // Load x5 in EX, ID reads rs2 = x5.
    ex_is_load = 1; ex_wb_en = 1; ex_rd_addr = 5; id_rs2_addr = 5; id_uses_rs2 = 1;
    #2;
    check("lu_pc_stall", pc_stall, 1);
    check("lu_idex_flush", id_ex_flush, 1);
    step();
    check("lu_cnt", stall_cnt, 1);
    ex_rd_addr = 0; id_rs2_addr = 0;
    step();
    check("lu_x0_cnt", stall_cnt, 1);
    idle_inputs();

    // Redirect in RUN takes effect in the same cycle.
    ex_redirect = 1; ex_redirect_pc = 32'h0000_0040;
    #2;
    check("redir_sel", pc_sel, 1);
    check("redir_pc", pc_redirect, 32'h40);
    check("redir_flush", {if_id_flush, id_ex_flush}, 2'b11);
    step();
    idle_inputs();

    // Memory wait with a redirect held; ack on the fourth cycle.
    mem_req = 1; ex_redirect = 1; ex_redirect_pc = 32'h80;
    repeat (3) step();
    mem_ack = 1;
    step();
    check("ack_to_redir", state_o, 2);
    idle_inputs();
    #2;
    check("redir_replay_pc", pc_redirect, 32'h80);
    step();
    check("back_to_run", state_o, 0);

    // Timeout into ERR, which holds until reset.
    mem_req = 1;
    repeat (TIMEOUT + 1) step();
    check("err_state", state_o, 3);
    check("err_flag", mem_err, 1);
    idle_inputs();
    repeat (3) step();
    do_reset();
    check("err_cleared", mem_err, 0);

    // Long stall run saturates the counter.
    mem_req = 1;
    repeat ((1 << CNT_W) + 2) step();
    check("cnt_saturated", stall_cnt, CNT_MAX);
    do_reset();

    // Reset asserted in the middle of a memory wait.
    mem_req = 1;
    repeat (2) step();
    rst = 0;
    #2;
    check("rst_flush", {if_id_flush, id_ex_flush}, 2'b11);
    check("rst_no_stall", pc_stall, 0);
    step();
    check("rst_mid_state", state_o, 0);
    check("rst_mid_cnt", stall_cnt, 0);
    idle_inputs();

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      rst            = ($urandom_range(0, 99) >= 3);
      if (m_mode == M_ERR && $urandom_range(0, 3) == 0) rst = 0;
      id_rs1_addr    = 5'($urandom_range(0, 3));
      id_rs2_addr    = 5'($urandom_range(0, 3));
      ex_rd_addr     = 5'($urandom_range(0, 3));
      id_uses_rs1    = 1'($urandom_range(0, 1));
      id_uses_rs2    = 1'($urandom_range(0, 1));
      ex_is_load     = 1'($urandom_range(0, 1));
      ex_wb_en       = ($urandom_range(0, 3) != 0);
      ex_redirect    = ($urandom_range(0, 4) == 0);
      ex_redirect_pc = $urandom;
      mem_req        = ($urandom_range(0, 9) < 3);
      mem_ack        = ($urandom_range(0, 9) < 4);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameters SHALL be:
- CNT_W, 16, width of stall_cnt.
- MEM_TIMEOUT, 255, maximum MEM_WAIT cycles before error.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- id_rs1_addr, id_rs2_addr  in  5  ID-stage source registers.
- id_uses_rs1, id_uses_rs2  in  1  source actually read.
- ex_rd_addr  in  5  EX-stage destination register.
- ex_is_load  in  1  EX instruction is a load.
- ex_wb_en  in  1  EX instruction writes back.
- ex_redirect  in  1  branch/jump taken, resolved in EX.
- ex_redirect_pc  in  32  redirect target.
- mem_req  in  1  memory-stage access pending.
- mem_ack  in  1  memory access complete.
- pc_stall, if_id_stall, id_ex_stall, ex_mem_stall  out  1  hold stage register.
- if_id_flush, id_ex_flush  out  1  load bubble (NOP) into stage register.
- pc_sel  out  1  PC takes pc_redirect.
- pc_redirect  out  32  redirect target.
- mem_err  out  1  sticky memory timeout flag.
- stall_cnt  out  CNT_W  saturating count of pc_stall cycles.
- state_o  out  2  current FSM state.

Function
REQ-003 States SHALL be RUN=0, MEM_WAIT=1, REDIR=2, ERR=3; state, pend, pend_pc, wait_cnt, stall_cnt, mem_err registered; stall/flush/pc outputs combinational from state and inputs (take effect same cycle).
REQ-004 Load-use hazard (lu) SHALL be: ex_is_load & ex_wb_en & ex_rd_addr!=0 & ((id_uses_rs1 & id_rs1_addr==ex_rd_addr) | (id_uses_rs2 & id_rs2_addr==ex_rd_addr)).
REQ-005 RUN priority SHALL be mem wait > redirect > load-use > idle.
REQ-006 RUN, mem_req & !mem_ack: all four stalls=1, flushes=0, pc_sel=0; next MEM_WAIT, wait_cnt<=1; if ex_redirect same cycle, pend<=1, pend_pc<=ex_redirect_pc.
REQ-007 RUN, no mem wait, ex_redirect: pc_sel=1, pc_redirect=ex_redirect_pc, if_id_flush=1, id_ex_flush=1, stalls=0; stay RUN; lu ignored that cycle.
REQ-008 RUN, lu only: pc_stall=1, if_id_stall=1, id_ex_flush=1, others 0; stay RUN; one cycle per hazard occurrence.
REQ-009 RUN otherwise: all stall/flush/pc_sel outputs 0.
REQ-010 MEM_WAIT, !mem_ack: all stalls=1, flushes=0, pc_sel=0; wait_cnt increments; ex_redirect with pend=0 latches pend/pend_pc (first wins).
REQ-011 MEM_WAIT, mem_ack: stalls=0, flushes=0, pc_sel=0 (redirect deferred); next REDIR if pend (or ex_redirect this cycle, latched) else RUN; wait_cnt<=0.
REQ-012 MEM_WAIT, !mem_ack, wait_cnt==MEM_TIMEOUT: next ERR, mem_err<=1.
REQ-013 REDIR: pc_sel=1, pc_redirect=pend_pc, if_id_flush=1, id_ex_flush=1, stalls=0; pend<=0; next RUN unconditionally.
REQ-014 ERR: all stalls=1, flushes=0, pc_sel=0; held until reset.
REQ-015 When a stage has both stall and flush asserted, flush SHALL take precedence.
REQ-016 pc_redirect SHALL be 0 whenever pc_sel=0.
REQ-017 stall_cnt SHALL increment on every cycle with pc_stall=1 and saturate at all-ones.

Reset
REQ-018 On a rising clk edge with rst=0: state=RUN, pend=0, pend_pc=0, wait_cnt=0, stall_cnt=0, mem_err=0.
REQ-019 While rst=0: all stalls=0, if_id_flush=id_ex_flush=1, pc_sel=0, pc_redirect=0, regardless of other inputs, including mid-MEM_WAIT or in ERR.

Verification
REQ-020 Bench SHALL cover:
- Load x5 in EX, ID reads rs2=x5 -> one cycle pc_stall=if_id_stall=id_ex_flush=1, stall_cnt=1; ex_rd_addr=0 -> no stall.
- ex_redirect=1, pc=0x0000_0040 in RUN -> same cycle pc_sel=1, pc_redirect=0x40, both flushes=1.
- mem_req=1, ack after 3 cycles with redirect 0x80 held -> 3 full-stall cycles, ack cycle all 0, next cycle REDIR with pc_redirect=0x80, then RUN.
- mem_req=1, no ack, MEM_TIMEOUT=4 -> ERR after 4 wait cycles, mem_err=1, stalls stay 1 until rst=0.
- rst=0 during MEM_WAIT -> next edge state_o=0, stall_cnt=0; flushes=1 while low.
- Force 2^CNT_W+2 stall cycles (CNT_W=4) -> stall_cnt holds 15.
